c3aibadapt_avmm_chain_ctrl: RTL



---
 rtl/c3aibadapt_avmm_chain_pkg.sv | 17 +
 rtl/c3aibadapt_avmm_rr_arb.sv | 35 +++
 rtl/c3aibadapt_avmm_chain_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/c3aibadapt_avmm_chain_pkg.sv
// rtl/c3aibadapt_avmm_chain_pkg.sv - shared types and constants for the AVMM chain sequencer
package c3aibadapt_avmm_chain_pkg;

    localparam int AVMM_DATA_W = 32;
    localparam int AVMM_BE_W   = 4;

    // Read data returned on an aborted (timed-out) access
    localparam logic [AVMM_DATA_W-1:0] TIMEOUT_RDATA = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RSP    = 2'd3
    } state_e;

endpackage

// File: rtl/c3aibadapt_avmm_rr_arb.sv
// rtl/c3aibadapt_avmm_rr_arb.sv - 2-way round-robin arbiter with last-grant pointer
module c3aibadapt_avmm_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_q;
    logic last_d;
    logic fire;

    // Contention goes to the requester not granted last; a lone requester always wins
    always_comb begin
        gnt_id = req[1] & (~req[0] | ~last_q);
        fire   = en & (|req);
        gnt    = 2'b00;
        if (fire) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
        last_d = fire ? gnt_id : last_q;
    end

    // Pointer resets to req1 so req0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/c3aibadapt_avmm_chain_ctrl.sv
// rtl/c3aibadapt_avmm_chain_ctrl.sv - AVMM chain master sequencer; timeout abort under C3AIBADAPT_AVMM_CHAIN_TIMEOUT_EN
module c3aibadapt_avmm_chain_ctrl
    import c3aibadapt_avmm_chain_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   i_avmm_clk,
    input  logic                   i_avmm_rst_n,
    input  logic                   i_req0_valid,
    input  logic                   i_req0_write,
    input  logic [ADDR_W-1:0]      i_req0_addr,
    input  logic [AVMM_DATA_W-1:0] i_req0_wdata,
    input  logic [AVMM_BE_W-1:0]   i_req0_byteen,
    output logic                   o_req0_ready,
    output logic                   o_req0_rsp_valid,
    output logic [AVMM_DATA_W-1:0] o_req0_rdata,
    output logic                   o_req0_err,
    input  logic                   i_req1_valid,
    input  logic                   i_req1_write,
    input  logic [ADDR_W-1:0]      i_req1_addr,
    input  logic [AVMM_DATA_W-1:0] i_req1_wdata,
    input  logic [AVMM_BE_W-1:0]   i_req1_byteen,
    output logic                   o_req1_ready,
    output logic                   o_req1_rsp_valid,
    output logic [AVMM_DATA_W-1:0] o_req1_rdata,
    output logic                   o_req1_err,
    output logic                   o_avmm_read,
    output logic                   o_avmm_write,
    output logic [ADDR_W-1:0]      o_avmm_addr,
    output logic [AVMM_DATA_W-1:0] o_avmm_wdata,
    output logic [AVMM_BE_W-1:0]   o_avmm_byteen,
    input  logic                   i_avmm_waitreq,
    input  logic                   i_avmm_rdatavalid,
    input  logic [AVMM_DATA_W-1:0] i_avmm_rdata,
    output logic                   o_busy
);

    state_e                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [AVMM_DATA_W-1:0] wdata_q, wdata_d;
    logic [AVMM_BE_W-1:0]   be_q, be_d;
    logic                   id_q, id_d;
    logic                   rd_stb_q, rd_stb_d;
    logic                   wr_stb_q, wr_stb_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [AVMM_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;

    logic [1:0]             arb_gnt;
    logic                   arb_id;
    logic                   arb_en;
    logic                   timeout_hit;

    assign arb_en = (state_q == ST_IDLE);

    c3aibadapt_avmm_rr_arb u_arb (
        .clk    (i_avmm_clk),
        .rst_n  (i_avmm_rst_n),
        .req    ({i_req1_valid, i_req0_valid}),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

`ifdef C3AIBADAPT_AVMM_CHAIN_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Last permitted stall cycle of the current phase
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Counter restarts on every phase change and counts cycles spent stalled in CMD/RDWAIT
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == ST_CMD || state_q == ST_RDWAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stall counter register
    always_ff @(posedge i_avmm_clk or negedge i_avmm_rst_n) begin
        if (!i_avmm_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Sequencer next-state: latch on grant, issue one command, collect one response
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        id_d        = id_q;
        rd_stb_d    = rd_stb_q;
        wr_stb_d    = wr_stb_q;
        rsp_valid_d = 2'b00;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt) begin
                    id_d = arb_id;
                    if (arb_id) begin
                        wr_d    = i_req1_write;
                        addr_d  = i_req1_addr;
                        wdata_d = i_req1_wdata;
                        be_d    = i_req1_byteen;
                    end else begin
                        wr_d    = i_req0_write;
                        addr_d  = i_req0_addr;
                        wdata_d = i_req0_wdata;
                        be_d    = i_req0_byteen;
                    end
                    rd_stb_d = ~wr_d;
                    wr_stb_d = wr_d;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!i_avmm_waitreq) begin
                    rd_stb_d = 1'b0;
                    wr_stb_d = 1'b0;
                    if (wr_q) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = id_q ? 2'b10 : 2'b01;
                        rsp_data_d  = '0;
                        err_d       = 1'b0;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end else if (timeout_hit) begin
                    rd_stb_d    = 1'b0;
                    wr_stb_d    = 1'b0;
                    state_d     = ST_RSP;
                    rsp_valid_d = id_q ? 2'b10 : 2'b01;
                    rsp_data_d  = TIMEOUT_RDATA;
                    err_d       = 1'b1;
                end
            end
            ST_RDWAIT: begin
                if (i_avmm_rdatavalid) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = id_q ? 2'b10 : 2'b01;
                    rsp_data_d  = i_avmm_rdata;
                    err_d       = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = id_q ? 2'b10 : 2'b01;
                    rsp_data_d  = TIMEOUT_RDATA;
                    err_d       = 1'b1;
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge i_avmm_clk or negedge i_avmm_rst_n) begin
        if (!i_avmm_rst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            id_q        <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            id_q        <= id_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // Ready is the only combinational output; held low while reset is asserted
    assign o_req0_ready     = arb_gnt[0] & i_avmm_rst_n;
    assign o_req1_ready     = arb_gnt[1] & i_avmm_rst_n;
    assign o_req0_rsp_valid = rsp_valid_q[0];
    assign o_req1_rsp_valid = rsp_valid_q[1];
    assign o_req0_rdata     = rsp_data_q;
    assign o_req1_rdata     = rsp_data_q;
`ifdef C3AIBADAPT_AVMM_CHAIN_TIMEOUT_EN
    assign o_req0_err       = err_q;
    assign o_req1_err       = err_q;
`else
    assign o_req0_err       = 1'b0;
    assign o_req1_err       = 1'b0;
`endif
    assign o_avmm_read      = rd_stb_q;
    assign o_avmm_write     = wr_stb_q;
    assign o_avmm_addr      = addr_q;
    assign o_avmm_wdata     = wdata_q;
    assign o_avmm_byteen    = be_q;
    assign o_busy           = busy_q;

endmodule
